// File: rtl/spu32_cpu_mul_pkg.sv
// ---------------------------------------------------------------------------
// spu32_cpu_mul_pkg
//
// Shared definitions for the M-extension multiply controller:
//   - 2-bit op encodings (MUL, MULH, MULHSU, MULHU)
//   - controller state encoding
//   - op_to_ctrl(): op -> {s1_signed, s2_signed, hi} for the multiplier
// ---------------------------------------------------------------------------
package spu32_cpu_mul_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] MUL_OP_MUL    = 2'd0;
  localparam logic [1:0] MUL_OP_MULH   = 2'd1;
  localparam logic [1:0] MUL_OP_MULHSU = 2'd2;
  localparam logic [1:0] MUL_OP_MULHU  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } mul_state_e;

  typedef struct packed {
    logic s1_signed;
    logic s2_signed;
    logic hi;
  } mul_ctrl_t;

  // rs1 is signed for MULH/MULHSU, rs2 only for MULH; every op except MUL
  // returns the upper half of the product.
  function automatic mul_ctrl_t op_to_ctrl(input logic [1:0] op);
    mul_ctrl_t c;
    c.s1_signed = (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU);
    c.s2_signed = (op == MUL_OP_MULH);
    c.hi        = (op != MUL_OP_MUL);
    return c;
  endfunction

endpackage

// File: rtl/spu32_cpu_mul_ctrl.sv
// ---------------------------------------------------------------------------
// spu32_cpu_mul_ctrl
//
// Sequencer between the execute stage and a multi-cycle shift-add multiplier.
// Accepts one multiply request (I_req && O_ready), registers operands and the
// derived signedness/hi controls, pulses O_mul_en for one cycle, waits for
// I_mul_busy to drop, captures the requested 32-bit half of the 64-bit
// product and holds it under an O_valid / I_ack handshake.
//
// Ports:
//   I_clk, I_reset          clock, synchronous active-high reset (shared with
//                           the multiplier)
//   I_req, I_op, I_s1, I_s2 request strobe, op (0 MUL, 1 MULH, 2 MULHSU,
//                           3 MULHU) and operands, sampled only on accept
//   O_ready                 high only in IDLE
//   O_valid, O_result       result handshake, held until I_ack
//   I_ack                   consumer takes the result
//   O_mul_en                one-cycle multiplier start
//   O_mul_s1, O_mul_s2      registered operands to the multiplier
//   O_mul_s1_signed,
//   O_mul_s2_signed,
//   O_mul_hi                registered multiplier controls
//   I_mul_result            64-bit product
//   I_mul_busy              multiplier busy flag
//
// Build option:
//   SPU32_MUL_FUSE_EN  keeps the last high-half product (operands, op, full
//                      64-bit product). A following MUL on the same operands,
//                      or the same hi op on the same operands, completes from
//                      the cache in one cycle without starting the multiplier.
// ---------------------------------------------------------------------------
module spu32_cpu_mul_ctrl
  import spu32_cpu_mul_pkg::*;
(
  input  logic        I_clk,
  input  logic        I_reset,
  input  logic        I_req,
  input  logic [1:0]  I_op,
  input  logic [31:0] I_s1,
  input  logic [31:0] I_s2,
  output logic        O_ready,
  output logic        O_valid,
  output logic [31:0] O_result,
  input  logic        I_ack,
  output logic        O_mul_en,
  output logic [31:0] O_mul_s1,
  output logic [31:0] O_mul_s2,
  output logic        O_mul_s1_signed,
  output logic        O_mul_s2_signed,
  output logic        O_mul_hi,
  input  logic [63:0] I_mul_result,
  input  logic        I_mul_busy
);

  mul_state_e  r_state;
  logic        r_ready;
  logic        r_valid;
  logic [31:0] r_result;
  logic        r_mul_en;
  logic [31:0] r_s1;
  logic [31:0] r_s2;
  logic        r_s1_signed;
  logic        r_s2_signed;
  logic        r_hi;

  mul_ctrl_t   w_req_ctrl;
  logic        w_accept;
  logic        w_mul_done;
  logic [31:0] w_done_result;
  logic        w_cache_hit;
  logic [31:0] w_cache_result;

  assign w_req_ctrl    = op_to_ctrl(I_op);
  assign w_accept      = I_req && r_ready;
  // Busy is only meaningful from WAIT on; START never looks at it.
  assign w_mul_done    = (r_state == ST_WAIT) && !I_mul_busy;
  assign w_done_result = r_hi ? I_mul_result[63:32] : I_mul_result[31:0];

`ifdef SPU32_MUL_FUSE_EN
  // -------------------------------------------------------------------------
  // Product cache: filled by every completed hi op, dropped by a completed
  // MUL (its high half was never computed with a known signedness) and by
  // reset. The low half of a product does not depend on signedness, so a MUL
  // may hit on any cached op; a hi op must match the cached op exactly.
  // -------------------------------------------------------------------------
  logic        r_cache_valid;
  logic [31:0] r_cache_s1;
  logic [31:0] r_cache_s2;
  logic [63:0] r_cache_prod;
  logic [1:0]  r_cache_op;
  logic [1:0]  r_op;

  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      r_cache_valid <= 1'b0;
      r_cache_s1    <= '0;
      r_cache_s2    <= '0;
      r_cache_prod  <= '0;
      r_cache_op    <= MUL_OP_MUL;
      r_op          <= MUL_OP_MUL;
    end else begin
      if (w_accept) begin
        r_op <= I_op;
      end
      if (w_mul_done) begin
        if (r_hi) begin
          r_cache_valid <= 1'b1;
          r_cache_s1    <= r_s1;
          r_cache_s2    <= r_s2;
          r_cache_prod  <= I_mul_result;
          r_cache_op    <= r_op;
        end else begin
          r_cache_valid <= 1'b0;
        end
      end
    end
  end

  assign w_cache_hit = r_cache_valid
                    && (I_s1 == r_cache_s1)
                    && (I_s2 == r_cache_s2)
                    && ((I_op == MUL_OP_MUL) || (I_op == r_cache_op));
  assign w_cache_result = (I_op == MUL_OP_MUL) ? r_cache_prod[31:0]
                                               : r_cache_prod[63:32];
`else
  assign w_cache_hit    = 1'b0;
  assign w_cache_result = 32'd0;
`endif

  // -------------------------------------------------------------------------
  // Main sequencer. O_ready, O_valid and O_mul_en are registered alongside
  // the state so every output comes straight from a flop.
  // -------------------------------------------------------------------------
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      r_state     <= ST_IDLE;
      r_ready     <= 1'b1;
      r_valid     <= 1'b0;
      r_result    <= '0;
      r_mul_en    <= 1'b0;
      r_s1        <= '0;
      r_s2        <= '0;
      r_s1_signed <= 1'b0;
      r_s2_signed <= 1'b0;
      r_hi        <= 1'b0;
    end else begin
      r_mul_en <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_s1        <= I_s1;
            r_s2        <= I_s2;
            r_s1_signed <= w_req_ctrl.s1_signed;
            r_s2_signed <= w_req_ctrl.s2_signed;
            r_hi        <= w_req_ctrl.hi;
            r_ready     <= 1'b0;
            if (w_cache_hit) begin
              r_result <= w_cache_result;
              r_valid  <= 1'b1;
              r_state  <= ST_DONE;
            end else begin
              // Start pulse is registered here so it is high exactly in START.
              r_mul_en <= 1'b1;
              r_state  <= ST_START;
            end
          end
        end

        ST_START: begin
          r_state <= ST_WAIT;
        end

        ST_WAIT: begin
          if (w_mul_done) begin
            r_result <= w_done_result;
            r_valid  <= 1'b1;
            r_state  <= ST_DONE;
          end
        end

        ST_DONE: begin
          if (I_ack) begin
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign O_ready         = r_ready;
  assign O_valid         = r_valid;
  assign O_result        = r_result;
  assign O_mul_en        = r_mul_en;
  assign O_mul_s1        = r_s1;
  assign O_mul_s2        = r_s2;
  assign O_mul_s1_signed = r_s1_signed;
  assign O_mul_s2_signed = r_s2_signed;
  assign O_mul_hi        = r_hi;

endmodule

// File: tb/tb_spu32_cpu_mul_ctrl.sv
// ---------------------------------------------------------------------------
// tb_spu32_cpu_mul_ctrl
//
// Directed bench for spu32_cpu_mul_ctrl with a behavioural shift-add
// multiplier: busy rises on the edge that sees O_mul_en and stays high for
// 1 + N cycles, N being the number of multiplier bits to scan (64 for a
// negative signed rs2, else index of highest set bit + 1, 0 for rs2 = 0).
// While busy the product bus carries junk so an early capture shows up.
// ---------------------------------------------------------------------------
module tb_spu32_cpu_mul_ctrl;
  import spu32_cpu_mul_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [1:0]  op;
  logic [31:0] s1;
  logic [31:0] s2;
  logic        ready;
  logic        valid;
  logic [31:0] result;
  logic        ack;
  logic        mul_en;
  logic [31:0] mul_s1;
  logic [31:0] mul_s2;
  logic        mul_s1_signed;
  logic        mul_s2_signed;
  logic        mul_hi;
  logic [63:0] mul_result;
  logic        mul_busy;

  int vectors = 0;
  int miscompares = 0;

`ifdef SPU32_MUL_FUSE_EN
  localparam bit FUSE = 1'b1;
`else
  localparam bit FUSE = 1'b0;
`endif

  always #5 clk = ~clk;

  spu32_cpu_mul_ctrl dut (
    .I_clk           (clk),
    .I_reset         (rst),
    .I_req           (req),
    .I_op            (op),
    .I_s1            (s1),
    .I_s2            (s2),
    .O_ready         (ready),
    .O_valid         (valid),
    .O_result        (result),
    .I_ack           (ack),
    .O_mul_en        (mul_en),
    .O_mul_s1        (mul_s1),
    .O_mul_s2        (mul_s2),
    .O_mul_s1_signed (mul_s1_signed),
    .O_mul_s2_signed (mul_s2_signed),
    .O_mul_hi        (mul_hi),
    .I_mul_result    (mul_result),
    .I_mul_busy      (mul_busy)
  );

  // ---------------- multiplier model ----------------
  function automatic int iter_count(input logic [31:0] b, input logic b_signed);
    if (b_signed && b[31]) return 64;
    for (int i = 31; i >= 0; i--) begin
      if (b[i]) return i + 1;
    end
    return 0;
  endfunction

  function automatic logic [63:0] prod_of(input logic [31:0] a, input logic [31:0] b,
                                          input logic a_signed, input logic b_signed);
    logic [63:0] ax;
    logic [63:0] bx;
    ax = a_signed ? {{32{a[31]}}, a} : {32'd0, a};
    bx = b_signed ? {{32{b[31]}}, b} : {32'd0, b};
    return ax * bx;
  endfunction

  logic [63:0] m_prod;
  int          m_cnt;

  always @(posedge clk) begin
    if (rst) begin
      mul_busy <= 1'b0;
      m_cnt    <= 0;
      m_prod   <= 64'd0;
    end else if (mul_en) begin
      mul_busy <= 1'b1;
      m_cnt    <= iter_count(mul_s2, mul_s2_signed);
      m_prod   <= prod_of(mul_s1, mul_s2, mul_s1_signed, mul_s2_signed);
    end else if (mul_busy) begin
      if (m_cnt == 0) mul_busy <= 1'b0;
      else            m_cnt    <= m_cnt - 1;
    end
  end

  assign mul_result = mul_busy ? 64'hDEAD_BEEF_CAFE_F00D : m_prod;

  // ---------------- stimulus helpers (no checks inside) ----------------
  // Called just after an edge with the DUT in IDLE; that cycle is T.
  // lat is the cycle offset from T at which O_valid is first seen.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int en_cnt, output logic [2:0] ctrl,
                       output logic [31:0] t1_s1, output logic [31:0] t1_s2,
                       output logic timed_out);
    req = 1'b1; op = o; s1 = a; s2 = b;
    @(posedge clk); #1;
    // Scramble request inputs: only the accept-cycle values may matter.
    req = 1'b0; op = ~o; s1 = ~a; s2 = b ^ 32'h5A5A_A5A5;
    lat    = 1;
    en_cnt = mul_en ? 1 : 0;
    ctrl   = {mul_s1_signed, mul_s2_signed, mul_hi};
    t1_s1  = mul_s1;
    t1_s2  = mul_s2;
    while (!valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (mul_en) en_cnt++;
    end
    timed_out = !valid;
    $display("op=%0d s1=%08h s2=%08h -> result=%08h latency=%0d starts=%0d",
             o, a, b, result, lat, en_cnt);
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got=%b exp=1", ready); end
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%b exp=0", valid); end
    vectors++; if (result !== 32'd0) begin miscompares++; $display("FAIL reset_result got=%08h exp=0", result); end
    vectors++; if (mul_en !== 1'b0) begin miscompares++; $display("FAIL reset_mul_en got=%b exp=0", mul_en); end
    vectors++; if ({mul_s1, mul_s2} !== 64'd0) begin miscompares++; $display("FAIL reset_operands got=%08h/%08h exp=0/0", mul_s1, mul_s2); end
    vectors++; if ({mul_s1_signed, mul_s2_signed, mul_hi} !== 3'b000) begin miscompares++; $display("FAIL reset_ctrl got=%b%b%b exp=000", mul_s1_signed, mul_s2_signed, mul_hi); end
  endtask

  task automatic test_mul_basic();
    int lat, en_cnt; logic [2:0] ctrl; logic [31:0] a1, a2; logic to;
    issue(MUL_OP_MUL, 32'd7, 32'd6, lat, en_cnt, ctrl, a1, a2, to);
    vectors++; if (to) begin miscompares++; $display("FAIL mul7x6_timeout got=no_valid exp=valid"); end
    vectors++; if (result !== 32'd42) begin miscompares++; $display("FAIL mul7x6_result got=%08h exp=0000002a", result); end
    vectors++; if (lat !== 7) begin miscompares++; $display("FAIL mul7x6_latency got=%0d exp=7", lat); end
    vectors++; if (en_cnt !== 1) begin miscompares++; $display("FAIL mul7x6_starts got=%0d exp=1", en_cnt); end
    vectors++; if (ctrl !== 3'b000) begin miscompares++; $display("FAIL mul7x6_ctrl got=%b exp=000", ctrl); end
    vectors++; if ({a1, a2} !== {32'd7, 32'd6}) begin miscompares++; $display("FAIL mul7x6_operands got=%08h/%08h exp=7/6", a1, a2); end
    do_ack();
    vectors++; if ({valid, ready} !== 2'b01) begin miscompares++; $display("FAIL mul7x6_after_ack got=valid%b/ready%b exp=valid0/ready1", valid, ready); end
  endtask

  task automatic test_hi_ops();
    logic [1:0]  ops [3];
    logic [31:0] exp_res [3];
    int          exp_lat [3];
    logic [2:0]  exp_ctrl [3];
    int lat, en_cnt; logic [2:0] ctrl; logic [31:0] a1, a2; logic to;
    ops[0] = MUL_OP_MULH;   exp_res[0] = 32'h0000_0000; exp_lat[0] = 68; exp_ctrl[0] = 3'b111;
    ops[1] = MUL_OP_MULHU;  exp_res[1] = 32'hFFFF_FFFE; exp_lat[1] = 36; exp_ctrl[1] = 3'b001;
    ops[2] = MUL_OP_MULHSU; exp_res[2] = 32'hFFFF_FFFF; exp_lat[2] = 36; exp_ctrl[2] = 3'b101;
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, en_cnt, ctrl, a1, a2, to);
      vectors++; if (to) begin miscompares++; $display("FAIL hi_op%0d_timeout got=no_valid exp=valid", ops[i]); end
      vectors++; if (result !== exp_res[i]) begin miscompares++; $display("FAIL hi_op%0d_result got=%08h exp=%08h", ops[i], result, exp_res[i]); end
      vectors++; if (lat !== exp_lat[i]) begin miscompares++; $display("FAIL hi_op%0d_latency got=%0d exp=%0d", ops[i], lat, exp_lat[i]); end
      vectors++; if (ctrl !== exp_ctrl[i]) begin miscompares++; $display("FAIL hi_op%0d_ctrl got=%b exp=%b", ops[i], ctrl, exp_ctrl[i]); end
      vectors++; if (en_cnt !== 1) begin miscompares++; $display("FAIL hi_op%0d_starts got=%0d exp=1", ops[i], en_cnt); end
      do_ack();
    end
  endtask

  task automatic test_hold();
    int lat, en_cnt; logic [2:0] ctrl; logic [31:0] a1, a2; logic to;
    int bad_cycles;
    issue(MUL_OP_MUL, 32'd3, 32'd4, lat, en_cnt, ctrl, a1, a2, to);
    vectors++; if (result !== 32'd12) begin miscompares++; $display("FAIL hold_result got=%08h exp=0000000c", result); end
    vectors++; if (lat !== 7) begin miscompares++; $display("FAIL hold_latency got=%0d exp=7", lat); end
    // Requests while busy must be ignored; consumer stalls for 10 cycles.
    req = 1'b1; op = MUL_OP_MULHU; s1 = 32'h1111_1111; s2 = 32'h2222_2222;
    bad_cycles = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      vectors++;
      if (valid !== 1'b1 || result !== 32'd12 || ready !== 1'b0 || mul_en !== 1'b0) begin
        miscompares++; bad_cycles++;
        $display("FAIL hold_cycle%0d got=valid%b/result%08h/ready%b/en%b exp=valid1/result0000000c/ready0/en0",
                 c, valid, result, ready, mul_en);
      end
    end
    req = 1'b0;
    do_ack();
    vectors++; if ({valid, ready} !== 2'b01) begin miscompares++; $display("FAIL hold_after_ack got=valid%b/ready%b exp=valid0/ready1", valid, ready); end
    @(posedge clk); #1;
    vectors++; if ({mul_en, ready} !== 2'b01) begin miscompares++; $display("FAIL hold_not_queued got=en%b/ready%b exp=en0/ready1", mul_en, ready); end
    $display("hold: %0d bad cycles while stalled", bad_cycles);
  endtask

  task automatic test_reset_mid_wait();
    int lat, en_cnt; logic [2:0] ctrl; logic [31:0] a1, a2; logic to;
    req = 1'b1; op = MUL_OP_MULHU; s1 = 32'hFFFF_FFFF; s2 = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    vectors++; if ({valid, ready, mul_busy} !== 3'b001) begin miscompares++; $display("FAIL midwait_in_wait got=valid%b/ready%b/busy%b exp=valid0/ready0/busy1", valid, ready, mul_busy); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    vectors++; if ({valid, ready, mul_en} !== 3'b010) begin miscompares++; $display("FAIL midwait_reset got=valid%b/ready%b/en%b exp=valid0/ready1/en0", valid, ready, mul_en); end
    vectors++; if (mul_hi !== 1'b0) begin miscompares++; $display("FAIL midwait_reset_hi got=%b exp=0", mul_hi); end
    issue(MUL_OP_MUL, 32'd3, 32'd5, lat, en_cnt, ctrl, a1, a2, to);
    vectors++; if (to) begin miscompares++; $display("FAIL mul3x5_timeout got=no_valid exp=valid"); end
    vectors++; if (result !== 32'd15) begin miscompares++; $display("FAIL mul3x5_result got=%08h exp=0000000f", result); end
    vectors++; if (lat !== 7) begin miscompares++; $display("FAIL mul3x5_latency got=%0d exp=7", lat); end
    do_ack();
  endtask

  task automatic test_s2_zero();
    int lat, en_cnt; logic [2:0] ctrl; logic [31:0] a1, a2; logic to;
    issue(MUL_OP_MUL, 32'h1234_5678, 32'd0, lat, en_cnt, ctrl, a1, a2, to);
    vectors++; if (result !== 32'd0) begin miscompares++; $display("FAIL s2zero_result got=%08h exp=00000000", result); end
    vectors++; if (lat !== 4) begin miscompares++; $display("FAIL s2zero_latency got=%0d exp=4", lat); end
    vectors++; if (a1 !== 32'h1234_5678) begin miscompares++; $display("FAIL s2zero_operand got=%08h exp=12345678", a1); end
    do_ack();
  endtask

  task automatic test_fuse();
    int lat, en_cnt; logic [2:0] ctrl; logic [31:0] a1, a2; logic to;
    issue(MUL_OP_MULHU, 32'h0001_0000, 32'h0001_0000, lat, en_cnt, ctrl, a1, a2, to);
    vectors++; if (result !== 32'd1) begin miscompares++; $display("FAIL fuse_mulhu_result got=%08h exp=00000001", result); end
    vectors++; if (lat !== 21) begin miscompares++; $display("FAIL fuse_mulhu_latency got=%0d exp=21", lat); end
    do_ack();
    issue(MUL_OP_MUL, 32'h0001_0000, 32'h0001_0000, lat, en_cnt, ctrl, a1, a2, to);
    vectors++; if (result !== 32'd0) begin miscompares++; $display("FAIL fuse_mul_result got=%08h exp=00000000", result); end
    vectors++; if (lat !== (FUSE ? 1 : 21)) begin miscompares++; $display("FAIL fuse_mul_latency got=%0d exp=%0d", lat, FUSE ? 1 : 21); end
    vectors++; if (en_cnt !== (FUSE ? 0 : 1)) begin miscompares++; $display("FAIL fuse_mul_starts got=%0d exp=%0d", en_cnt, FUSE ? 0 : 1); end
    do_ack();
    vectors++; if ({valid, ready} !== 2'b01) begin miscompares++; $display("FAIL fuse_after_ack got=valid%b/ready%b exp=valid0/ready1", valid, ready); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1; req = 1'b0; op = 2'd0; s1 = '0; s2 = '0; ack = 1'b0;
    test_reset();
    test_mul_basic();
    test_hi_ops();
    test_hold();
    test_reset_mid_wait();
    test_s2_zero();
    test_fuse();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spu32_cpu_mul_ctrl.md
Name: spu32_cpu_mul_ctrl

Overview:
- Sequencer between the CPU execute stage and the multi-cycle shift-add multiplier (64-bit result, busy flag).
- Accepts one M-extension multiply request: op selects MUL, MULH, MULHSU or MULHU.
- Derives the multiplier's signedness and hi controls, starts it, waits for completion, selects the 32-bit result half, and holds it under a valid/ack handshake.

Parameters:
- none (XLEN fixed at 32)

Ports:
- I_clk  in  1  clock
- I_reset  in  1  synchronous active-high reset; the same signal also resets the multiplier
- I_req  in  1  request strobe; accepted when I_req && O_ready
- I_op  in  2  0=MUL 1=MULH 2=MULHSU 3=MULHU
- I_s1  in  32  operand rs1
- I_s2  in  32  operand rs2
- O_ready  out  1  high only in IDLE
- O_valid  out  1  result valid; held until acknowledged
- O_result  out  32  selected result half
- I_ack  in  1  consumer takes result
- O_mul_en  out  1  multiplier start
- O_mul_s1  out  32  registered operand 1
- O_mul_s2  out  32  registered operand 2
- O_mul_s1_signed  out  1  op in {MULH, MULHSU}
- O_mul_s2_signed  out  1  op == MULH
- O_mul_hi  out  1  op != MUL
- I_mul_result  in  64  multiplier product
- I_mul_busy  in  1  multiplier busy

Behaviour:
- Reset values:
  - state=IDLE, O_ready=1, O_valid=0, O_result=0, O_mul_en=0
  - operand registers and control registers (O_mul_s1, O_mul_s2, signed flags, hi) = 0
- States IDLE, START, WAIT, DONE. Accept cycle is T.
  - IDLE: on I_req, register I_s1, I_s2 and the control bits derived from I_op → START.
  - START (T+1): O_mul_en=1 for exactly this cycle → WAIT.
  - WAIT: from T+2 the multiplier reports busy=1. The first cycle with I_mul_busy==0 latches the result half and moves to DONE.
    - MUL: O_result = I_mul_result[31:0].
    - MULH, MULHSU, MULHU: O_result = I_mul_result[63:32].
  - DONE: O_valid=1; O_result is stable while in DONE. On I_ack → IDLE, and O_valid falls next cycle.
    - ack in the DONE entry cycle is legal.
    - No new request is accepted in the cycle of ack, because O_ready is 0 in DONE.
- Latency, accept to O_valid:
  - s2 = 0: T+4.
  - MUL: T+4+(index of highest set bit of s2)+1, at most T+36.
  - hi ops with negative s2 under MULH: up to T+68.
- The controller never samples I_mul_busy in START.
- I_req while not ready is ignored and not queued; the requester holds it.
- I_op and operands are sampled only at acceptance; later changes have no effect.
- Reset at any state, including mid-WAIT: next cycle is IDLE with O_valid=0. The multiplier is reset by the same signal, so no stale completion is ever observed.

Optional Feature:
- Macro: SPU32_MUL_FUSE_EN.
- Defined:
  - Keep last s1, s2, the full 64-bit product, and cache_valid.
  - Set cache_valid after any completed MULH/MULHSU/MULHU.
  - Clear cache_valid on reset and after a completed MUL.
  - A MUL request whose operands match a valid cache entry goes IDLE→DONE. It asserts O_valid at T+1 with the cached low half (the low half is independent of signedness) and O_mul_en stays 0.
  - A hi-op request hits only if operands and op also match the cached op.
- Undefined: no cache registers; every request runs the full sequence.

Decomposition:
- Package spu32_cpu_mul_pkg:
  - op encodings MUL_OP_MUL/MULH/MULHSU/MULHU (2-bit)
  - state encoding constants
  - helper function op→{s1_signed, s2_signed, hi}
- No sub-module required. With SPU32_MUL_FUSE_EN, the operand-match cache may be split out as spu32_cpu_mul_fuse_cache.

Test Plan:
- MUL 7×6 → O_result=42; O_valid at T+4+3 (s2=6, highest set bit 2); O_mul_en is high exactly once.
- MULH 0xFFFFFFFF×0xFFFFFFFF → 0x00000000. MULHU with the same operands → 0xFFFFFFFE. MULHSU with the same operands → 0xFFFFFFFF. Check the signed/hi control outputs per op.
- Hold I_ack low for 10 cycles after O_valid → O_valid and O_result stable, O_ready=0, extra I_req ignored.
- Assert I_reset in WAIT during a MULHU → next cycle IDLE, O_valid=0, O_ready=1; a following MUL 3×5 → 15.
- s2=0 (MUL 0x12345678×0) → result 0 at T+4. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE within T+36.
- SPU32_MUL_FUSE_EN: MULHU 0x10000×0x10000 (→1), then MUL with the same operands → O_valid at T+1 with 0, O_mul_en never asserted. Without the macro → full latency, same value.
